// File: rtl/mips_pkg.sv
// Shared defaults and helpers for the pipeline register file family.
package mips_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int REG_ZERO     = 0;

    // Smallest w with 2**w >= n; used to size register addresses exactly.
    function automatic int addr_width(input int n);
        int w;
        w = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, write-with-clear clears, flush wipes all.
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int AW       = addr_width(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WR-1:0]    i_wr_en,
    input  logic [NUM_WR*AW-1:0] i_wr_addr,
    input  logic [NUM_WR-1:0]    i_wr_clr,
    input  logic                 i_iss_valid,
    input  logic [AW-1:0]        i_iss_addr,
    input  logic                 i_flush,
    input  logic [NUM_RD*AW-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]    o_rd_busy,
    output logic                 o_any_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Priority: clear < issue < flush; register 0 can never become busy.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (i_wr_en[j] && i_wr_clr[j]) begin
                w_busy_nxt[i_wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (i_iss_valid) begin
            w_busy_nxt[i_iss_addr] = 1'b1;
        end
        if (i_flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A same-cycle clearing write bypasses its data, so the reader sees it as ready.
    always_comb begin
        o_rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            o_rd_busy[i] = r_busy[i_rd_addr[i*AW +: AW]];
            for (int j = 0; j < NUM_WR; j++) begin
                if (i_wr_en[j] && i_wr_clr[j] &&
                    (i_wr_addr[j*AW +: AW] == i_rd_addr[i*AW +: AW])) begin
                    o_rd_busy[i] = 1'b0;
                end
            end
        end
    end

    assign o_any_busy = |r_busy;

endmodule

// File: rtl/multiport_regfile_sb.sv
// Multi-ported register file with write-to-read bypass, zero register, PC and busy scoreboard.
module multiport_regfile_sb
    import mips_pkg::*;
#(
    parameter int              DATA_W   = DEF_DATA_W,
    parameter int              NUM_REGS = DEF_NUM_REGS,
    parameter int              NUM_RD   = 2,
    parameter int              NUM_WR   = 1,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEF_RESET_PC),
    localparam int             AW       = addr_width(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR-1:0]        wr_clr,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_addr,
    input  logic                     flush,
    input  logic                     pc_write,
    input  logic [DATA_W-1:0]        pc_next,
    output logic [DATA_W-1:0]        pc_out,
    output logic                     any_busy
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_pc;

    // Later ports overwrite earlier ones, giving the highest index priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO))) begin
                    r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = r_regs[rd_addr[i*AW +: AW]];
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                end
            end
            if (rd_addr[i*AW +: AW] == AW'(REG_ZERO)) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (pc_write) begin
            r_pc <= pc_next;
        end
    end

    assign pc_out = r_pc;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .AW       (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_clr    (wr_clr),
        .i_iss_valid (iss_valid),
        .i_iss_addr  (iss_addr),
        .i_flush     (flush),
        .i_rd_addr   (rd_addr),
        .o_rd_busy   (rd_busy),
        .o_any_busy  (any_busy)
    );

endmodule

// File: tb/tb_multiport_regfile_sb.sv
// Directed bench for multiport_regfile_sb (2 read, 2 write ports) with an expected-value queue.
module tb_multiport_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic             clk;
    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic [NW-1:0]    wr_clr;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic             flush;
    logic             pc_write;
    logic [DW-1:0]    pc_next;
    logic [DW-1:0]    pc_out;
    logic             any_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t expQ[$];

    multiport_regfile_sb #(
        .DATA_W   (DW),
        .NUM_REGS (32),
        .NUM_RD   (NR),
        .NUM_WR   (NW),
        .RESET_PC (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_clr    (wr_clr),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .pc_write  (pc_write),
        .pc_next   (pc_next),
        .pc_out    (pc_out),
        .any_busy  (any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pushExp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL queue_empty observed=%h expected=<none>", obs);
        end else begin
            e = expQ.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_clr    = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        flush     = 1'b0;
        pc_write  = 1'b0;
        pc_next   = 32'hDEAD_0000;
    endtask

    task automatic setWrite(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic clr);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
        wr_clr[p]           = clr;
    endtask

    task automatic setRead(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    // Advance past the next rising edge; inputs are then driven away from it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdData(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    initial begin
        idle();
        setRead(5'd0, 5'd0);
        rst = 1'b0;
        pc_write = 1'b1;
        pc_next  = 32'h40;
        applyStimulus();
        applyStimulus();
        #1;
        pushExp("pc_in_reset", 32'h0);
        checkOutput(pc_out);
        idle();
        rst = 1'b1;
        #1;
        pushExp("pc_after_reset", 32'h0);
        checkOutput(pc_out);
        pushExp("any_busy_reset", 32'h0);
        checkOutput(32'(any_busy));
        for (int k = 0; k < 16; k++) begin
            setRead(5'(2*k), 5'(2*k+1));
            #1;
            pushExp("rd_data0_reset", 32'h0);
            checkOutput(rdData(0));
            pushExp("rd_data1_reset", 32'h0);
            checkOutput(rdData(1));
            pushExp("rd_busy_reset", 32'h0);
            checkOutput(32'(rd_busy));
        end

        // Write r5 and read it in the same cycle, then the next.
        applyStimulus();
        idle();
        setWrite(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
        setRead(5'd5, 5'd3);
        #1;
        pushExp("bypass_r5", 32'hDEAD_BEEF);
        checkOutput(rdData(0));
        applyStimulus();
        idle();
        #1;
        pushExp("stored_r5", 32'hDEAD_BEEF);
        checkOutput(rdData(0));

        // Zero register ignores write and issue.
        applyStimulus();
        idle();
        setWrite(0, 5'd0, 32'h1234, 1'b0);
        iss_valid = 1'b1;
        iss_addr  = 5'd0;
        setRead(5'd0, 5'd0);
        #1;
        pushExp("r0_bypass_p0", 32'h0);
        checkOutput(rdData(0));
        pushExp("r0_bypass_p1", 32'h0);
        checkOutput(rdData(1));
        applyStimulus();
        idle();
        #1;
        pushExp("r0_stored", 32'h0);
        checkOutput(rdData(0));
        pushExp("r0_busy", 32'h0);
        checkOutput(32'(rd_busy));
        pushExp("r0_any_busy", 32'h0);
        checkOutput(32'(any_busy));

        // Two ports write r7 together; port 1 wins.
        applyStimulus();
        idle();
        setWrite(0, 5'd7, 32'h11, 1'b0);
        setWrite(1, 5'd7, 32'h22, 1'b0);
        setRead(5'd7, 5'd7);
        #1;
        pushExp("collide_bypass0", 32'h22);
        checkOutput(rdData(0));
        pushExp("collide_bypass1", 32'h22);
        checkOutput(rdData(1));
        applyStimulus();
        idle();
        #1;
        pushExp("collide_stored", 32'h22);
        checkOutput(rdData(0));
        pushExp("r5_untouched", 32'hDEAD_BEEF);
        setRead(5'd5, 5'd7);
        #1;
        checkOutput(rdData(0));

        // Scoreboard: issue r9, then clear it with a write.
        applyStimulus();
        idle();
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        setRead(5'd9, 5'd8);
        #1;
        pushExp("busy_r9_issue_cycle", 32'h0);
        checkOutput(32'(rd_busy));
        applyStimulus();
        idle();
        #1;
        pushExp("busy_r9_after_issue", 32'h1);
        checkOutput(32'(rd_busy));
        pushExp("any_busy_r9", 32'h1);
        checkOutput(32'(any_busy));
        applyStimulus();
        idle();
        setWrite(1, 5'd9, 32'h99, 1'b1);
        #1;
        pushExp("busy_r9_clear_cycle", 32'h0);
        checkOutput(32'(rd_busy));
        pushExp("data_r9_clear_cycle", 32'h99);
        checkOutput(rdData(0));
        applyStimulus();
        idle();
        #1;
        pushExp("busy_r9_after_clear", 32'h0);
        checkOutput(32'(rd_busy));
        pushExp("any_busy_after_clear", 32'h0);
        checkOutput(32'(any_busy));

        // Issue and clear r9 together: the issue wins.
        applyStimulus();
        idle();
        setWrite(0, 5'd9, 32'hAA, 1'b1);
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        applyStimulus();
        idle();
        #1;
        pushExp("busy_r9_issue_beats_clear", 32'h1);
        checkOutput(32'(rd_busy));

        // Three busy registers, then flush alongside an issue.
        iss_valid = 1'b1;
        iss_addr  = 5'd10;
        applyStimulus();
        idle();
        iss_valid = 1'b1;
        iss_addr  = 5'd11;
        applyStimulus();
        idle();
        setRead(5'd10, 5'd11);
        #1;
        pushExp("busy_r10_r11", 32'h3);
        checkOutput(32'(rd_busy));
        flush     = 1'b1;
        iss_valid = 1'b1;
        iss_addr  = 5'd12;
        applyStimulus();
        idle();
        #1;
        pushExp("any_busy_after_flush", 32'h0);
        checkOutput(32'(any_busy));
        setRead(5'd9, 5'd12);
        #1;
        pushExp("busy_after_flush", 32'h0);
        checkOutput(32'(rd_busy));

        // PC load, three stalls (one with an r29 write), then reload.
        pc_write = 1'b1;
        pc_next  = 32'h100;
        applyStimulus();
        for (int s = 0; s < 3; s++) begin
            idle();
            if (s == 1) begin
                setWrite(0, 5'd29, 32'h0000_0104, 1'b0);
            end
            #1;
            pushExp("pc_stall", 32'h100);
            checkOutput(pc_out);
            applyStimulus();
        end
        idle();
        pc_write = 1'b1;
        pc_next  = 32'h104;
        setRead(5'd29, 5'd0);
        #1;
        pushExp("pc_before_reload", 32'h100);
        checkOutput(pc_out);
        pushExp("r29_stored", 32'h104);
        checkOutput(rdData(0));
        applyStimulus();
        idle();
        #1;
        pushExp("pc_reload", 32'h104);
        checkOutput(pc_out);

        // Asynchronous reset in the middle of a busy cycle.
        setWrite(0, 5'd5, 32'h55, 1'b0);
        iss_valid = 1'b1;
        iss_addr  = 5'd5;
        pc_write  = 1'b1;
        pc_next   = 32'h200;
        #1;
        rst = 1'b0;
        #1;
        pushExp("pc_async_reset", 32'h0);
        checkOutput(pc_out);
        applyStimulus();
        idle();
        rst = 1'b1;
        setRead(5'd5, 5'd29);
        #1;
        pushExp("r5_after_reset", 32'h0);
        checkOutput(rdData(0));
        pushExp("r29_after_reset", 32'h0);
        checkOutput(rdData(1));
        pushExp("any_busy_after_reset", 32'h0);
        checkOutput(32'(any_busy));
        pushExp("pc_held_reset", 32'h0);
        checkOutput(pc_out);

        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL queue_leftover observed=%0d expected=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
